// File: rtl/led_sequencer_if.sv
// Configuration-table write port and downstream interval-counter handshake
// shared between the LED sequencer (slave) and its host/counter side (master).
interface led_sequencer_if #(
   parameter int LED_W = 8
);
   logic             cfg_we;
   logic [2:0]       cfg_addr;
   logic [LED_W-1:0] cfg_pattern;
   logic [31:0]      cfg_duration;
   logic             ctr_reset;
   logic [31:0]      ctr_limit;
   logic             ctr_limit_we;
   logic             ctr_enable;
   logic             ctr_limit_reached;

   modport master (
      output cfg_we, cfg_addr, cfg_pattern, cfg_duration, ctr_limit_reached,
      input  ctr_reset, ctr_limit, ctr_limit_we, ctr_enable
   );

   modport slave (
      input  cfg_we, cfg_addr, cfg_pattern, cfg_duration, ctr_limit_reached,
      output ctr_reset, ctr_limit, ctr_limit_we, ctr_enable
   );
endinterface

// File: rtl/led_sequencer.sv
// Steps through an 8-entry LED pattern table, timing each step with an
// external interval counter that is cleared, loaded and enabled per step.
//
// state | meaning
// IDLE  | stopped, leds dark, step retained for resume
// CLEAR | pulse ctr_reset to the interval counter
// LOAD  | write step duration to counter, show step pattern
// WAIT  | counter enabled until ctr_limit_reached
// NEXT  | step advanced; run decides CLEAR or IDLE
module led_sequencer #(
   parameter int LED_W = 8,
   parameter int STEPS = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             run,
   led_sequencer_if.slave   bus,
   output logic [LED_W-1:0] leds,
   output logic [2:0]       step,
   output logic             busy,
   output logic             wrap_pulse
);

   localparam logic [2:0] ST_IDLE  = 3'd0;
   localparam logic [2:0] ST_CLEAR = 3'd1;
   localparam logic [2:0] ST_LOAD  = 3'd2;
   localparam logic [2:0] ST_WAIT  = 3'd3;
   localparam logic [2:0] ST_NEXT  = 3'd4;

   logic [2:0]       state;
   logic [LED_W-1:0] pat_tbl [STEPS];
   logic [31:0]      dur_tbl [STEPS];
   logic [31:0]      ctr_limit_q;

   always_ff @(posedge clk) begin
      if (!reset) begin
         state       <= ST_IDLE;
         step        <= 3'd0;
         leds        <= '0;
         ctr_limit_q <= '0;
         wrap_pulse  <= 1'b0;
         for (int i = 0; i < STEPS; i++) begin
            pat_tbl[i] <= '0;
            dur_tbl[i] <= '0;
         end
      end else begin
         // Table reads below see the pre-edge contents, so a write to the
         // active entry only shows up at that entry's next LOAD.
         if (bus.cfg_we) begin
            pat_tbl[bus.cfg_addr] <= bus.cfg_pattern;
            dur_tbl[bus.cfg_addr] <= bus.cfg_duration;
         end
         wrap_pulse <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (run) state <= ST_CLEAR;
            end
            ST_CLEAR: begin
               state       <= ST_LOAD;
               leds        <= pat_tbl[step];
               ctr_limit_q <= dur_tbl[step];
            end
            ST_LOAD: begin
               state <= ST_WAIT;
            end
            ST_WAIT: begin
               if (bus.ctr_limit_reached) begin
                  state      <= ST_NEXT;
                  step       <= step + 3'd1;
                  wrap_pulse <= (step == 3'd7);
               end
            end
            ST_NEXT: begin
               if (run) begin
                  state <= ST_CLEAR;
               end else begin
                  state <= ST_IDLE;
                  leds  <= '0;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   assign bus.ctr_reset    = (state == ST_CLEAR);
   assign bus.ctr_limit_we = (state == ST_LOAD);
   assign bus.ctr_enable   = (state == ST_WAIT);
   assign bus.ctr_limit    = ctr_limit_q;
   assign busy             = (state != ST_IDLE);

endmodule

// File: tb/tb_led_sequencer.sv
// Directed bench for led_sequencer: a cycle-level reference model checked on
// every falling edge, plus literal expectations at the key cycles.
module tb_led_sequencer;

   logic       clk;
   logic       reset;
   logic       run;
   logic [7:0] leds;
   logic [2:0] step;
   logic       busy;
   logic       wrap_pulse;

   led_sequencer_if #(.LED_W(8)) bus ();

   led_sequencer #(.LED_W(8), .STEPS(8)) dut (
      .clk        (clk),
      .reset      (reset),
      .run        (run),
      .bus        (bus),
      .leds       (leds),
      .step       (step),
      .busy       (busy),
      .wrap_pulse (wrap_pulse)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Reference model: a step is "in progress" for t cycles since its counter
   // clear; t==0 clear, t==1 load, t>=2 waiting; after completion it sits one
   // cycle in the advance phase before either restarting or stopping.
   logic [7:0]  m_pat [8];
   logic [31:0] m_dur [8];
   bit          m_idle;
   bit          m_adv;
   int          m_t;
   int          m_step;
   logic [7:0]  m_leds;
   logic [31:0] m_limit;
   bit          m_wrap;
   bit          m_valid = 1'b0;

   always @(posedge clk) begin
      if (!reset) begin
         for (int i = 0; i < 8; i++) begin
            m_pat[i] = 8'h00;
            m_dur[i] = 32'h0;
         end
         m_idle = 1'b1; m_adv = 1'b0; m_t = 0; m_step = 0;
         m_leds = 8'h00; m_limit = 32'h0; m_wrap = 1'b0;
      end else begin
         m_wrap = 1'b0;
         if (m_idle) begin
            if (run) begin m_idle = 1'b0; m_adv = 1'b0; m_t = 0; end
         end else if (m_adv) begin
            if (run) begin m_adv = 1'b0; m_t = 0; end
            else begin m_idle = 1'b1; m_adv = 1'b0; m_leds = 8'h00; end
         end else if (m_t == 0) begin
            m_t = 1;
            m_leds = m_pat[m_step];
            m_limit = m_dur[m_step];
         end else if (m_t == 1) begin
            m_t = 2;
         end else if (bus.ctr_limit_reached) begin
            m_adv = 1'b1;
            m_wrap = (m_step == 7);
            m_step = (m_step + 1) % 8;
         end
         if (bus.cfg_we) begin
            m_pat[bus.cfg_addr] = bus.cfg_pattern;
            m_dur[bus.cfg_addr] = bus.cfg_duration;
         end
      end
      m_valid = 1'b1;
   end

   always @(negedge clk) begin
      if (m_valid) begin
         chk("m_leds",       leds,             m_leds);
         chk("m_step",       step,             m_step[2:0]);
         chk("m_busy",       busy,             !m_idle);
         chk("m_wrap",       wrap_pulse,       m_wrap);
         chk("m_ctr_limit",  bus.ctr_limit,    m_limit);
         chk("m_ctr_reset",  bus.ctr_reset,    !m_idle && !m_adv && m_t == 0);
         chk("m_ctr_we",     bus.ctr_limit_we, !m_idle && !m_adv && m_t == 1);
         chk("m_ctr_enable", bus.ctr_enable,   !m_idle && !m_adv && m_t >= 2);
         chk("m_excl", bus.ctr_reset && bus.ctr_limit_we, 1'b0);
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wr(input logic [2:0] a, input logic [7:0] p, input logic [31:0] d);
      bus.cfg_we = 1'b1; bus.cfg_addr = a; bus.cfg_pattern = p; bus.cfg_duration = d;
      tick();
      bus.cfg_we = 1'b0;
   endtask

   // From WAIT: linger, then report the counter done; returns in NEXT.
   task automatic finish_step(input int linger);
      repeat (linger) tick();
      bus.ctr_limit_reached = 1'b1;
      tick();
      bus.ctr_limit_reached = 1'b0;
   endtask

   // From IDLE or NEXT with run high: CLEAR, LOAD, then WAIT.
   task automatic start_step();
      repeat (3) tick();
   endtask

   initial begin
      bus.cfg_we = 1'b0; bus.cfg_addr = 3'd0; bus.cfg_pattern = 8'h00;
      bus.cfg_duration = 32'h0; bus.ctr_limit_reached = 1'b0;
      reset = 1'b0; run = 1'b1;

      // Reset held two cycles with run high and a write that must be ignored
      bus.cfg_we = 1'b1; bus.cfg_pattern = 8'hFF; bus.cfg_duration = 32'd9;
      tick(); tick();
      chk("rst_leds", leds, 8'h00);
      chk("rst_step", step, 3'd0);
      chk("rst_busy", busy, 1'b0);
      chk("rst_en",   bus.ctr_enable, 1'b0);
      bus.cfg_we = 1'b0;
      reset = 1'b1;
      tick();
      chk("rst_clear_pulse", bus.ctr_reset, 1'b1);
      run = 1'b0;
      tick();
      chk("rst_load_leds",  leds, 8'h00);
      chk("rst_load_limit", bus.ctr_limit, 32'h0);
      chk("rst_load_we",    bus.ctr_limit_we, 1'b1);
      tick();
      finish_step(0);
      tick();
      chk("stop_idle_step", step, 3'd1);
      reset = 1'b0; tick(); reset = 1'b1;
      chk("rerst_step", step, 3'd0);

      wr(3'd0, 8'h01, 32'd5);
      wr(3'd1, 8'h02, 32'd7);
      for (int i = 2; i < 8; i++)
         wr(i[2:0], 8'(1 << i), (i == 3) ? 32'd0 : 32'(i));

      // Start and advance, run raised in cycle T
      run = 1'b1;
      tick();
      chk("t1_ctr_reset", bus.ctr_reset, 1'b1);
      tick();
      chk("t2_we",    bus.ctr_limit_we, 1'b1);
      chk("t2_limit", bus.ctr_limit, 32'd5);
      chk("t2_leds",  leds, 8'h01);
      tick();
      chk("t3_en", bus.ctr_enable, 1'b1);
      repeat (7) tick();
      bus.ctr_limit_reached = 1'b1;
      tick();
      bus.ctr_limit_reached = 1'b0;
      chk("t11_en",   bus.ctr_enable, 1'b0);
      tick();
      chk("t12_step", step, 3'd1);
      chk("t12_rst",  bus.ctr_reset, 1'b1);
      tick();
      chk("t13_limit", bus.ctr_limit, 32'd7);
      chk("t13_leds",  leds, 8'h02);

      // Live write to the active entry while waiting
      tick();
      wr(3'd1, 8'hAA, 32'd3);
      chk("live_leds_held", leds, 8'h02);
      finish_step(1);
      chk("live_next_leds", leds, 8'h02);
      for (int s = 2; s < 8; s++) begin
         start_step();
         finish_step((s == 3) ? 0 : 1);
      end
      chk("wrap_pulse", wrap_pulse, 1'b1);
      chk("wrap_step",  step, 3'd0);
      tick();
      chk("wrap_once", wrap_pulse, 1'b0);
      tick();
      chk("wrap_leds", leds, 8'h01);
      tick();
      finish_step(1);
      tick(); tick();
      chk("live_leds_new",  leds, 8'hAA);
      chk("live_limit_new", bus.ctr_limit, 32'd3);
      tick();

      // Stop mid-step: step completes, then IDLE with advanced step
      run = 1'b0;
      tick(); tick();
      finish_step(0);
      chk("stop_next_leds", leds, 8'hAA);
      tick();
      chk("stop_leds", leds, 8'h00);
      chk("stop_busy", busy, 1'b0);
      chk("stop_step", step, 3'd2);

      // Counter done flag must be ignored outside WAIT
      bus.ctr_limit_reached = 1'b1;
      tick(); tick();
      chk("ign_idle_busy", busy, 1'b0);
      run = 1'b1;
      tick(); tick();
      chk("resume_leds",  leds, 8'h04);
      chk("resume_limit", bus.ctr_limit, 32'd2);
      bus.ctr_limit_reached = 1'b0;
      tick(); tick();
      chk("ign_step", step, 3'd2);
      chk("ign_en",   bus.ctr_enable, 1'b1);

      // Reset during WAIT
      reset = 1'b0;
      tick();
      reset = 1'b1;
      chk("mid_en",    bus.ctr_enable, 1'b0);
      chk("mid_leds",  leds, 8'h00);
      chk("mid_busy",  busy, 1'b0);
      chk("mid_step",  step, 3'd0);
      chk("mid_limit", bus.ctr_limit, 32'h0);
      tick(); tick();
      chk("mid_tbl_leds",  leds, 8'h00);
      chk("mid_tbl_limit", bus.ctr_limit, 32'h0);
      run = 1'b0;
      tick();
      finish_step(0);
      tick();
      chk("end_busy", busy, 1'b0);

      @(negedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
